// File: rtl/acc_sched_pkg.sv
`default_nettype none
// ============================================================================
// acc_sched_pkg : shared op/state types for the accumulator scheduler
// Rev 1.0
// ============================================================================
package acc_sched_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      ADD   = 2'd0,
      SUB   = 2'd1,
      LOAD  = 2'd2,
      CLEAR = 2'd3
   } acc_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } acc_state_e;

endpackage
`default_nettype wire

// File: rtl/acc_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request at or above ptr
// Rev 1.0
// ============================================================================
module rr_arbiter
   import acc_sched_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // One extra bit so ptr + offset can exceed N before folding back.
   logic [IDX_W:0] w_cand;

   always_comb begin
      grant  = '0;
      idx    = '0;
      any    = 1'b0;
      w_cand = '0;
      for (int i = 0; i < N; i++) begin
         w_cand = {1'b0, ptr} + (IDX_W+1)'(i);
         if (w_cand >= (IDX_W+1)'(N)) begin
            w_cand = w_cand - (IDX_W+1)'(N);
         end
         if (!any && req[w_cand[IDX_W-1:0]]) begin
            any                       = 1'b1;
            idx                       = w_cand[IDX_W-1:0];
            grant[w_cand[IDX_W-1:0]]  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/acc_scheduler.sv
`default_nettype none
// ============================================================================
// acc_scheduler : round-robin shared 8-bit accumulator; ACC_SAT_EN selects
//                 saturating ADD/SUB instead of wrap-around
// Rev 1.0
// ============================================================================
module acc_scheduler
   import acc_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [OP_W*NUM_REQ-1:0]    req_op,
   input  logic [DATA_W*NUM_REQ-1:0]  req_data,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [$clog2(NUM_REQ)-1:0] resp_id,
   output logic [DATA_W-1:0]          resp_data,
   output logic                       resp_ovf,
   output logic [DATA_W-1:0]          acc_value,
   output logic [15:0]                op_count,
   output logic                       busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   acc_state_e        r_state;
   acc_op_e           r_op;
   logic [DATA_W-1:0] r_data;
   logic [ID_W-1:0]   r_id;
   logic [ID_W-1:0]   r_ptr;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_idx;
   logic               w_any;
   logic [DATA_W:0]    w_sum;
   logic [DATA_W:0]    w_diff;
   logic [DATA_W-1:0]  w_next_acc;
   logic               w_next_ovf;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (r_ptr),
      .grant (w_grant),
      .idx   (w_idx),
      .any   (w_any)
   );

   // Ready is gated by reset so nothing is offered while reset_n is low.
   assign req_ready = (reset_n && (r_state == IDLE)) ? w_grant : '0;
   assign busy      = (r_state != IDLE);

   assign w_sum  = {1'b0, acc_value} + {1'b0, r_data};
   assign w_diff = {1'b0, acc_value} - {1'b0, r_data};

   always_comb begin
      w_next_acc = acc_value;
      w_next_ovf = 1'b0;
      case (r_op)
         ADD: begin
`ifdef ACC_SAT_EN
            w_next_acc = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
`else
            w_next_acc = w_sum[DATA_W-1:0];
`endif
            w_next_ovf = w_sum[DATA_W];
         end
         SUB: begin
`ifdef ACC_SAT_EN
            w_next_acc = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
`else
            w_next_acc = w_diff[DATA_W-1:0];
`endif
            w_next_ovf = w_diff[DATA_W];
         end
         LOAD:    w_next_acc = r_data;
         CLEAR:   w_next_acc = '0;
         default: w_next_acc = acc_value;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_op       <= ADD;
         r_data     <= '0;
         r_id       <= '0;
         r_ptr      <= '0;
         acc_value  <= '0;
         op_count   <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
         resp_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op    <= acc_op_e'(req_op[OP_W*int'(w_idx) +: OP_W]);
                  r_data  <= req_data[DATA_W*int'(w_idx) +: DATA_W];
                  r_id    <= w_idx;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               acc_value  <= w_next_acc;
               resp_data  <= w_next_acc;
               resp_ovf   <= w_next_ovf;
               resp_id    <= r_id;
               resp_valid <= 1'b1;
               r_ptr      <= (r_id == ID_W'(NUM_REQ-1)) ? '0 : r_id + 1'b1;
               r_state    <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  op_count   <= op_count + 16'd1;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_acc_scheduler.sv
`default_nettype none
// ============================================================================
// tb_acc_scheduler : directed + randomized bench against a transaction model
// Rev 1.0
// ============================================================================
module tb_acc_scheduler;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int MAXV = (1 << DW) - 1;
   localparam logic [1:0] OP_ADD   = 2'd0;
   localparam logic [1:0] OP_SUB   = 2'd1;
   localparam logic [1:0] OP_LOAD  = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   logic            clock;
   logic            reset_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [2*N-1:0]  req_op;
   logic [DW*N-1:0] req_data;
   logic            resp_valid;
   logic            resp_ready;
   logic [1:0]      resp_id;
   logic [DW-1:0]   resp_data;
   logic            resp_ovf;
   logic [DW-1:0]   acc_value;
   logic [15:0]     op_count;
   logic            busy;

   acc_scheduler #(
      .NUM_REQ (N),
      .DATA_W  (DW)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_data   (req_data),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_ovf   (resp_ovf),
      .acc_value  (acc_value),
      .op_count   (op_count),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: accumulator, round-robin pointer, completed count
   int m_acc, m_ptr, m_cnt;
   bit         p_valid [N];
   logic [1:0] p_op    [N];
   logic [7:0] p_data  [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = p_valid[i];
         req_op[2*i +: 2]      = p_op[i];
         req_data[DW*i +: DW]  = p_data[i];
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         if (p_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_op(input logic [1:0] op, input logic [7:0] d, output int res, output int ovf);
      int s;
      res = m_acc;
      ovf = 0;
      case (op)
         OP_ADD: begin
            s   = m_acc + int'(d);
            ovf = (s > MAXV) ? 1 : 0;
`ifdef ACC_SAT_EN
            res = ovf ? MAXV : s;
`else
            res = s % (MAXV + 1);
`endif
         end
         OP_SUB: begin
            s   = m_acc - int'(d);
            ovf = (s < 0) ? 1 : 0;
`ifdef ACC_SAT_EN
            res = ovf ? 0 : s;
`else
            res = (s + MAXV + 1) % (MAXV + 1);
`endif
         end
         OP_LOAD: res = int'(d);
         default: res = 0;
      endcase
   endtask

   task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] d);
      p_valid[id] = 1'b1;
      p_op[id]    = op;
      p_data[id]  = d;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      resp_ready = 1'b0;
      #1;
      check("rst_acc", acc_value, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_op_count", op_count, 0);
      check("rst_resp_fields", {resp_id, resp_ovf, resp_data}, 0);
      m_acc = 0;
      m_ptr = 0;
      m_cnt = 0;
      for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
      drive_reqs();
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // One full transaction starting in an IDLE cycle, 1 time unit after an edge.
   task automatic run_txn(input int stall);
      int w, exp_res, exp_ovf;
      logic [N-1:0] exp_ready;
      drive_reqs();
      #1;
      w = pick();
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      check("req_ready_grant", req_ready, exp_ready);
      check("busy_idle", busy, 0);
      if (w < 0) return;
      model_op(p_op[w], p_data[w], exp_res, exp_ovf);
      @(posedge clock);
      #1;
      p_valid[w] = 1'b0;
      drive_reqs();
      check("exec_resp_valid", resp_valid, 0);
      check("exec_busy", busy, 1);
      check("exec_req_ready", req_ready, 0);
      resp_ready = (stall == 0);
      @(posedge clock);
      #1;
      m_acc = exp_res;
      m_ptr = (w + 1) % N;
      check("resp_valid", resp_valid, 1);
      check("resp_id", resp_id, w);
      check("resp_data", resp_data, exp_res);
      check("resp_ovf", resp_ovf, exp_ovf);
      check("acc_value", acc_value, exp_res);
      check("op_count_pre", op_count, m_cnt);
      for (int s = 0; s < stall; s++) begin
         @(posedge clock);
         #1;
         check("stall_valid", resp_valid, 1);
         check("stall_fields", {resp_id, resp_ovf, resp_data}, {2'(w), 1'(exp_ovf), 8'(exp_res)});
         check("stall_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      m_cnt = (m_cnt + 1) % 65536;
      resp_ready = 1'b0;
      check("post_resp_valid", resp_valid, 0);
      check("op_count", op_count, m_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      resp_ready = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, OP_ADD, 8'h01);
      drive_reqs();
      do_reset();

      // Single LOAD from requester 0
      set_req(0, OP_LOAD, 8'h10);
      run_txn(0);

      // All four ADD 1 from reset: grant order 0,1,2,3
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, OP_ADD, 8'h01);
      repeat (N) run_txn(0);
      check("acc_after_four", acc_value, 4);

      // Carry out of 0xFF
      set_req(1, OP_LOAD, 8'hFF);
      run_txn(0);
      set_req(2, OP_ADD, 8'h01);
      run_txn(0);

      // Response stalled 5 cycles while requester 1 waits
      set_req(0, OP_ADD, 8'h05);
      set_req(1, OP_ADD, 8'h07);
      run_txn(5);
      run_txn(0);

      // Reset while a transaction is in EXEC
      set_req(3, OP_ADD, 8'h55);
      drive_reqs();
      #1;
      check("pre_rst_grant", req_ready, 4'b1000);
      @(posedge clock);
      #1;
      check("pre_rst_busy", busy, 1);
      do_reset();
      set_req(0, OP_ADD, 8'h03);
      set_req(3, OP_ADD, 8'h04);
      run_txn(0);
      run_txn(1);

      // Lone requester 2, borrow on first SUB
      set_req(2, OP_LOAD, 8'h02);
      run_txn(0);
      set_req(2, OP_SUB, 8'h03);
      run_txn(0);
      set_req(2, OP_SUB, 8'h03);
      run_txn(0);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         bit any_p;
         any_p = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!p_valid[i] && ($urandom_range(0, 1) == 1)) begin
               set_req(i, 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            end
            any_p = any_p | p_valid[i];
         end
         if (!any_p) set_req($urandom_range(0, N-1), OP_SUB, 8'($urandom_range(0, 255)));
         run_txn($urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/acc_scheduler.md
# acc_scheduler

Round-robin scheduler that shares one 8-bit accumulator datapath among several requesters. Each requester issues add/sub/load/clear operations through a valid/ready handshake. The block serialises them, applies each to the accumulator, and returns the post-operation value tagged with the requester id. It sits between counter-style producers and the shared accumulator register, and is the sole writer of that register.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, accumulator and operand width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_op  in  2*NUM_REQ  per-requester op: 0 ADD, 1 SUB, 2 LOAD, 3 CLEAR
- req_data  in  DATA_W*NUM_REQ  per-requester operand; ignored for CLEAR
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  $clog2(NUM_REQ)  index of the served requester
- resp_data  out  DATA_W  accumulator value after the op
- resp_ovf  out  1  carry on ADD / borrow on SUB
- acc_value  out  DATA_W  current accumulator
- op_count  out  16  completed transactions, wraps at 0xFFFF→0
- busy  out  1  high in EXEC or RESP

Reset is asynchronous and active-low. The clock port is named `clock`.

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - The arbiter picks the first asserted req_valid at or after rr_ptr, searching upward with wrap.
  - req_ready[winner]=1 combinationally; all other ready bits are 0.
  - On the handshake, capture op, data and id, then go to EXEC. With no valid request, stay in IDLE.
- EXEC (one cycle):
  - acc_value ← f(acc, op, data).
  - ADD and SUB are computed at DATA_W+1 bits; the low DATA_W bits are kept (wrap).
  - resp_ovf ← bit DATA_W of the result, which is carry for ADD and borrow for SUB.
  - LOAD and CLEAR set resp_ovf=0. CLEAR sets acc=0.
  - Set rr_ptr ← (id+1) mod NUM_REQ and go to RESP.
- RESP:
  - resp_valid=1; resp_data, resp_id and resp_ovf are held stable.
  - On resp_ready, increment op_count and go to IDLE.
  - With resp_ready low, stall indefinitely; no new request is accepted.
- Requesters must hold req_valid, req_op and req_data until their own ready. A request dropped before ready is simply not served.

## Timing
- Request handshake at edge t. acc_value is updated at t+1. resp_valid is high from t+1.
- Earliest next accept is the cycle after the response handshake. Peak throughput is 1 op per 3 cycles.
- Reset values (async assertion clears immediately):
  - state=IDLE, acc_value=0, rr_ptr=0, op_count=0.
  - resp_valid=0, resp_id=0, resp_data=0, resp_ovf=0.
  - busy=0, req_ready=0 while reset_n low.
- Reset mid-transaction drops the transaction: no response is issued and acc returns to 0.
- All requesters valid: grant order is 0,1,2,3,0,… from reset.
- A lone requester is granted back-to-back; the pointer passing it does not block it.
- ADD 0xFF+0x01 → 0x00, ovf=1. SUB 0x00−0x01 → 0xFF, ovf=1.

## Configuration
- ACC_SAT_EN defined:
  - ADD clamps at 2^DATA_W−1 and SUB clamps at 0.
  - resp_ovf=1 whenever clamping occurred.
- ACC_SAT_EN undefined: wrap-around arithmetic as above.

## Structure
- Package acc_sched_pkg holds:
  - acc_op_e enum (ADD, SUB, LOAD, CLEAR)
  - acc_state_e enum (IDLE, EXEC, RESP)
  - OP_W=2 constant
- Sub-module rr_arbiter (parameter N): req vector plus pointer in, one-hot grant and encoded index out; purely combinational. The pointer register stays in acc_scheduler.

## Test plan
- Reset, then req0 LOAD 0x10 with resp_ready=1 → resp_data=0x10, resp_id=0, resp_ovf=0, resp_valid seen one cycle after accept, op_count=1.
- All four valid with ADD 1 each, resp_ready=1 → resp_id sequence 0,1,2,3; acc_value=0x04; op_count=4.
- acc=0xFF, ADD 0x01 → resp_data=0x00, ovf=1. With ACC_SAT_EN, expect resp_data=0xFF, ovf=1 instead.
- resp_ready held low 5 cycles with req1 pending → resp_valid stays high, req_ready stays 0, resp fields stay stable. On release, req1 is accepted the following cycle.
- reset_n pulsed low during EXEC → acc_value=0, resp_valid=0 immediately; after release, req0 is granted first.
- Only req2 valid repeatedly (SUB 0x03 from acc=0x02) → back-to-back grants to id 2; first resp_data=0xFF, ovf=1.
